board_led_scan: RTL and testbench



---
 rtl/board_led_scan.sv | 167 ++++++++++++++++
 tb/tb_board_led_scan.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/board_led_scan.sv
// board_led_scan: clock-enable strobes plus a paged LED scanner for accelerator results.
// A captured result is shown LED_W bits at a time, each page held for DWELL cycles,
// followed by a blank gap of DWELL cycles, looping until the next result arrives.
// Optional feature macro: LED_HEARTBEAT_EN (idle heartbeat on the top LED).
module board_led_scan #(
  parameter int DATA_W  = 10,
  parameter int LED_W   = 4,
  parameter int DWELL   = 50_000_000,
  parameter int CE1_DIV = 2,
  parameter int CE2_DIV = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] res_data,
  input  logic              res_valid,
  output logic              ce1,
  output logic              ce2,
  output logic [LED_W-1:0]  led,
  output logic              busy
);

  localparam int PAGES   = (DATA_W + LED_W - 1) / LED_W;
  localparam int SH_W    = PAGES * LED_W;
  localparam int MAX_A   = (DWELL > CE1_DIV) ? DWELL : CE1_DIV;
  localparam int MAX_DIV = (MAX_A > CE2_DIV) ? MAX_A : CE2_DIV;
  localparam int CNT_W   = (MAX_DIV > 1) ? $clog2(MAX_DIV) : 1;
  localparam int PG_W    = (PAGES > 1) ? $clog2(PAGES) : 1;

  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);
  localparam logic [CNT_W-1:0] CE1_LAST   = CNT_W'(CE1_DIV - 1);
  localparam logic [CNT_W-1:0] CE2_LAST   = CNT_W'(CE2_DIV - 1);
  localparam logic [PG_W-1:0]  PAGE_LAST  = PG_W'(PAGES - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SHOW = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;

  logic [CNT_W-1:0] ce1_cnt, ce2_cnt;
  logic [1:0]       state, state_n;
  logic [PG_W-1:0]  page, page_n;
  logic [CNT_W-1:0] dwell, dwell_n;
  logic [SH_W-1:0]  shadow, shadow_n;
  logic [LED_W-1:0] led_n;
  logic             dwell_last;
`ifdef LED_HEARTBEAT_EN
  logic             hb, hb_n;
`endif

  assign dwell_last = (dwell == DWELL_LAST);

  // ce1 generator: free-running counter, strobe registered one cycle after terminal count.
  // NOTE: sequential state always uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ce1_cnt <= '0;
      ce1     <= 1'b0;
    end else begin
      ce1     <= (ce1_cnt == CE1_LAST);
      ce1_cnt <= (ce1_cnt == CE1_LAST) ? '0 : ce1_cnt + CNT_W'(1);
    end
  end

  // ce2 generator: same scheme with its own divider.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ce2_cnt <= '0;
      ce2     <= 1'b0;
    end else begin
      ce2     <= (ce2_cnt == CE2_LAST);
      ce2_cnt <= (ce2_cnt == CE2_LAST) ? '0 : ce2_cnt + CNT_W'(1);
    end
  end

  // Scanner next state: a new result always wins over any dwell expiry.
  // NOTE: every variable gets a default at the top so no path can infer a latch.
  always_comb begin
    state_n  = state;
    page_n   = page;
    dwell_n  = dwell;
    shadow_n = shadow;
`ifdef LED_HEARTBEAT_EN
    hb_n     = hb;
`endif
    if (res_valid) begin
      shadow_n = SH_W'(res_data);
      page_n   = '0;
      dwell_n  = '0;
      state_n  = S_SHOW;
`ifdef LED_HEARTBEAT_EN
      hb_n     = 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
`ifdef LED_HEARTBEAT_EN
          dwell_n = dwell_last ? '0 : dwell + CNT_W'(1);
          if (dwell_last) hb_n = ~hb;
`endif
        end
        S_SHOW: begin
          if (dwell_last) begin
            dwell_n = '0;
            if (page == PAGE_LAST) state_n = S_GAP;
            else                   page_n  = page + PG_W'(1);
          end else begin
            dwell_n = dwell + CNT_W'(1);
          end
        end
        S_GAP: begin
          if (dwell_last) begin
            dwell_n = '0;
            page_n  = '0;
            state_n = S_SHOW;
          end else begin
            dwell_n = dwell + CNT_W'(1);
          end
        end
        default: begin
          state_n = S_IDLE;
          dwell_n = '0;
          page_n  = '0;
        end
      endcase
    end
  end

  // LED value for the upcoming cycle, derived from next state so capture shows page 0 at once.
  always_comb begin
    led_n = '0;
    case (state_n)
      S_SHOW:  led_n = shadow_n[int'(page_n)*LED_W +: LED_W];
      S_GAP:   led_n = '0;
      default: begin
`ifdef LED_HEARTBEAT_EN
        led_n[LED_W-1] = hb_n;
`endif
      end
    endcase
  end

  // Scanner registers including the result shadow and registered LED/busy outputs.
  // NOTE: the shadow is a plain register, not a memory, so it can take the async reset to 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      page   <= '0;
      dwell  <= '0;
      shadow <= '0;
      led    <= '0;
      busy   <= 1'b0;
`ifdef LED_HEARTBEAT_EN
      hb     <= 1'b0;
`endif
    end else begin
      state  <= state_n;
      page   <= page_n;
      dwell  <= dwell_n;
      shadow <= shadow_n;
      led    <= led_n;
      busy   <= (state_n != S_IDLE);
`ifdef LED_HEARTBEAT_EN
      hb     <= hb_n;
`endif
    end
  end

endmodule

// File: tb/tb_board_led_scan.sv
// Testbench for board_led_scan with DWELL=4, DATA_W=10, LED_W=4, CE1_DIV=2, CE2_DIV=4.
// A time-based model (edge count since reset, capture edge, captured word) predicts
// every output each cycle; directed sequences add literal expectations.
module tb_board_led_scan;

  localparam int DATA_W  = 10;
  localparam int LED_W   = 4;
  localparam int DWELL   = 4;
  localparam int CE1_DIV = 2;
  localparam int CE2_DIV = 4;
  localparam int PAGES   = (DATA_W + LED_W - 1) / LED_W;
`ifdef LED_HEARTBEAT_EN
  localparam bit HB = 1'b1;
`else
  localparam bit HB = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n;
  logic [DATA_W-1:0] res_data;
  logic              res_valid;
  logic              ce1, ce2, busy;
  logic [LED_W-1:0]  led;

  int checks = 0;
  int errors = 0;

  board_led_scan #(
    .DATA_W (DATA_W),
    .LED_W  (LED_W),
    .DWELL  (DWELL),
    .CE1_DIV(CE1_DIV),
    .CE2_DIV(CE2_DIV)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .res_data (res_data),
    .res_valid(res_valid),
    .ce1      (ce1),
    .ce2      (ce2),
    .led      (led),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model state: edges since reset release, whether/when a result was captured, and its value.
  int                n    = 0;
  bit                cap  = 1'b0;
  int                kc   = 0;
  logic [DATA_W-1:0] mdata = '0;

  always @(posedge clk) begin
    if (!rst_n) begin
      n   = 0;
      cap = 1'b0;
    end else begin
      n++;
      if (res_valid) begin
        cap   = 1'b1;
        kc    = n;
        mdata = res_data;
      end
    end
  end

  function automatic logic [LED_W-1:0] exp_led();
    int t, pg, d;
    if (!cap) begin
      if (HB && ((n / DWELL) % 2 == 1)) return LED_W'(1 << (LED_W - 1));
      return '0;
    end
    t  = (n - kc) % ((PAGES + 1) * DWELL);
    pg = t / DWELL;
    d  = int'(mdata);
    if (pg < PAGES) return LED_W'(d >> (pg * LED_W));
    return '0;
  endfunction

  // Per-cycle comparison against the model, sampled on the falling edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_led",  32'(led),  32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_ce1",  32'(ce1),  32'd0);
      check("rst_ce2",  32'(ce2),  32'd0);
    end else if (n >= 1) begin
      check("model_led",  32'(led),  32'(exp_led()));
      check("model_busy", 32'(busy), 32'(cap));
      check("model_ce1",  32'(ce1),  32'(n % CE1_DIV == 0));
      check("model_ce2",  32'(ce2),  32'(n % CE2_DIV == 0));
    end
  end

  logic [LED_W-1:0] exp_scan [20];
  int c1, c2;

  initial begin
    exp_scan = '{4'h5, 4'h5, 4'h5, 4'h5, 4'hB, 4'hB, 4'hB, 4'hB, 4'h2, 4'h2,
                 4'h2, 4'h2, 4'h0, 4'h0, 4'h0, 4'h0, 4'h5, 4'h5, 4'h5, 4'h5};
    rst_n     = 1'b0;
    res_valid = 1'b0;
    res_data  = '0;
    repeat (3) @(negedge clk);
    check("reset_led",  32'(led),  32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_ce1",  32'(ce1),  32'd0);
    check("reset_ce2",  32'(ce2),  32'd0);

    // Idle after release: CE pulse trains over 40 cycles and idle LED.
    rst_n = 1'b1;
    c1 = 0;
    c2 = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      c1 += int'(ce1);
      c2 += int'(ce2);
      if (i == 5) check("idle_led_n5", 32'(led), HB ? 32'h8 : 32'h0);
    end
    check("ce1_pulses_40", 32'(c1), 32'd20);
    check("ce2_pulses_40", 32'(c2), 32'd10);

    // Full scan of 10'h2B5 with a one-cycle strobe.
    res_data  = 10'h2B5;
    res_valid = 1'b1;
    for (int j = 0; j < 20; j++) begin
      @(negedge clk);
      if (j == 0) res_valid = 1'b0;
      check($sformatf("scan_%0d", j), 32'(led), 32'(exp_scan[j]));
      if (j == 13) check("scan_busy_gap", 32'(busy), 32'd1);
    end

    // Recapture 10'h3FF during the second GAP cycle.
    res_data  = 10'h2B5;
    res_valid = 1'b1;
    for (int j = 0; j <= 26; j++) begin
      @(negedge clk);
      case (j)
        13: check("gap2_led", 32'(led), 32'h0);
        14: check("recap_p0_first", 32'(led), 32'hF);
        17: check("recap_p0_last", 32'(led), 32'hF);
        18: check("recap_p1", 32'(led), 32'hF);
        22: check("recap_p2", 32'(led), 32'h3);
        26: check("recap_gap", 32'(led), 32'h0);
        default: ;
      endcase
      if (j == 0) res_valid = 1'b0;
      if (j == 13) begin
        res_data  = 10'h3FF;
        res_valid = 1'b1;
      end
      if (j == 14) res_valid = 1'b0;
    end

    // Capture in the last cycle of page 1 beats the page advance.
    res_data  = 10'h2B5;
    res_valid = 1'b1;
    for (int j = 0; j <= 12; j++) begin
      @(negedge clk);
      case (j)
        7:  check("simul_p1_last", 32'(led), 32'hB);
        8:  check("simul_new_p0", 32'(led), 32'h6);
        11: check("simul_new_p0_end", 32'(led), 32'h6);
        12: check("simul_new_p1", 32'(led), 32'hA);
        default: ;
      endcase
      if (j == 0) res_valid = 1'b0;
      if (j == 7) begin
        res_data  = 10'h1A6;
        res_valid = 1'b1;
      end
      if (j == 8) res_valid = 1'b0;
    end

    // Level-held strobe keeps showing page 0 of the latest data.
    res_data  = 10'h123;
    res_valid = 1'b1;
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      check("level_led", 32'(led), 32'h3);
    end
    res_valid = 1'b0;
    repeat (6) @(negedge clk);

    // Asynchronous reset in the middle of page 1.
    res_data  = 10'h2B5;
    res_valid = 1'b1;
    for (int j = 0; j <= 5; j++) begin
      @(negedge clk);
      if (j == 0) res_valid = 1'b0;
    end
    check("pre_reset_p1", 32'(led), 32'hB);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_led",  32'(led),  32'd0);
    check("async_busy", 32'(busy), 32'd0);
    check("async_ce1",  32'(ce1),  32'd0);
    check("async_ce2",  32'(ce2),  32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("post_reset_busy", 32'(busy), 32'd0);
    check("post_reset_led",  32'(led),  32'd0);
    repeat (10) @(negedge clk);

    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
